// File: rtl/demux_striping_n_pkg.sv
// Shared constants, lane-index type and pointer-advance helpers for the striping demux.
// Lane masking is compiled in only when DEMUX_LANE_MASK_EN is defined.
package demux_striping_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int LANES_DEF  = 4;
  localparam int MAX_LANES  = 64;

  typedef logic [$clog2(LANES_DEF)-1:0] lane_idx_t;

`ifdef DEMUX_LANE_MASK_EN
  // Next enabled lane after cur, wrapping; returns cur when no lane is enabled.
  function automatic int unsigned next_lane(input int unsigned cur, input int unsigned lanes,
                                            input logic [MAX_LANES-1:0] en);
    int unsigned nxt;
    int unsigned cand;
    logic        found;
    nxt   = cur;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_LANES; k++) begin
      if (!found && k <= lanes) begin
        cand = cur + k;
        if (cand >= lanes) cand = cand - lanes;
        if (en[cand]) begin
          nxt   = cand;
          found = 1'b1;
        end
      end
    end
    return nxt;
  endfunction

  function automatic int unsigned first_lane(input int unsigned lanes,
                                             input logic [MAX_LANES-1:0] en);
    int unsigned fst;
    logic        found;
    fst   = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_LANES; k++) begin
      if (!found && k < lanes && en[k]) begin
        fst   = k;
        found = 1'b1;
      end
    end
    return fst;
  endfunction
`else
  function automatic int unsigned next_lane(input int unsigned cur, input int unsigned lanes);
    return (cur + 1 >= lanes) ? 0 : cur + 1;
  endfunction
`endif

endpackage

// File: rtl/demux_striping_n_if.sv
// Bus bundle between the input stream source and the per-lane consumers.
interface demux_striping_n_if
  import demux_striping_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF
);
  localparam int PTR_W = $clog2(LANES);

  logic [DATA_W-1:0]       data_in;
  logic                    valid_in;
  logic                    in_ready;
  logic                    realign;
  logic [LANES-1:0]        lane_en;
  logic [LANES-1:0]        ready_lane;
  logic [LANES*DATA_W-1:0] data_out;
  logic [LANES-1:0]        valid_out;
  logic [PTR_W-1:0]        ptr_out;

  modport master (
    output data_in, valid_in, realign, lane_en, ready_lane,
    input  in_ready, data_out, valid_out, ptr_out
  );

  modport slave (
    input  data_in, valid_in, realign, lane_en, ready_lane,
    output in_ready, data_out, valid_out, ptr_out
  );
endinterface

// File: rtl/demux_striping_n_stripe_lane_reg.sv
// One-entry output register for a single lane; a load in the same cycle as a drain keeps it full.
module stripe_lane_reg
  import demux_striping_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic              load_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/demux_striping_n.sv
// Round-robin striping demux: rotation pointer, input ready and LANES lane registers.
// Optional lane masking is enabled with DEMUX_LANE_MASK_EN.
module demux_striping_n
  import demux_striping_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF
) (
  input logic              clk_2f,
  input logic              reset_L,
  demux_striping_n_if.slave bus
);

  localparam int PTR_W = $clog2(LANES);

  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [DATA_W-1:0]       lane_data [LANES];
  logic                    lane_valid [LANES];
  logic [LANES*DATA_W-1:0] data_flat;
  logic [LANES-1:0]        valid_flat;
  logic                    sel_valid, sel_ready, sel_en;
  logic                    in_ready, acc;
  int unsigned             ptr_u, ptr_next, ptr_first;

  always_comb begin
    sel_valid = 1'b0;
    sel_ready = 1'b0;
    sel_en    = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (ptr_q == PTR_W'(i)) begin
        sel_valid = lane_valid[i];
        sel_ready = bus.ready_lane[i];
`ifdef DEMUX_LANE_MASK_EN
        sel_en    = bus.lane_en[i];
`endif
      end
    end
  end

  assign in_ready = reset_L && sel_en && (!sel_valid || sel_ready);
  assign acc      = bus.valid_in && in_ready;
  assign ptr_u    = 32'(ptr_q);

`ifdef DEMUX_LANE_MASK_EN
  assign ptr_next  = next_lane(ptr_u, LANES, MAX_LANES'(bus.lane_en));
  assign ptr_first = first_lane(LANES, MAX_LANES'(bus.lane_en));
`else
  logic unused_lane_en;
  assign unused_lane_en = ^bus.lane_en;
  assign ptr_next       = next_lane(ptr_u, LANES);
  assign ptr_first      = 0;
`endif

  // A disabled current lane is stepped past even without an accept.
  always_comb begin
    ptr_d = ptr_q;
    if (bus.realign) begin
      ptr_d = PTR_W'(ptr_first);
    end else if (acc || !sel_en) begin
      ptr_d = PTR_W'(ptr_next);
    end
  end

  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    stripe_lane_reg #(.DATA_W(DATA_W)) u_lane (
      .clk_2f  (clk_2f),
      .reset_L (reset_L),
      .load_i  (acc && (ptr_q == PTR_W'(g))),
      .ready_i (bus.ready_lane[g]),
      .data_i  (bus.data_in),
      .data_o  (lane_data[g]),
      .valid_o (lane_valid[g])
    );
  end

  always_comb begin
    data_flat  = '0;
    valid_flat = '0;
    for (int i = 0; i < LANES; i++) begin
      data_flat[i*DATA_W +: DATA_W] = lane_data[i];
      valid_flat[i]                 = lane_valid[i];
    end
  end

  assign bus.data_out  = data_flat;
  assign bus.valid_out = valid_flat;
  assign bus.in_ready  = in_ready;
  assign bus.ptr_out   = ptr_q;

endmodule
